xdma_axil_csr_irq: RTL and testbench

// - AXI4-Lite control/status register slave on the XDMA m_axil BAR port; sits between the xdma_0 core and user logic.
// - Host reads ID/heartbeat/link status, writes scratch/control, raises user interrupts.
// - Drives the XDMA usr_irq_req/usr_irq_ack handshake from host- or logic-triggered pending bits.

---
 rtl/xdma_axil_csr_irq_pkg.sv | 31 +++
 rtl/xdma_axil_csr_irq_if.sv | 32 +++
 rtl/xdma_axil_csr_irq_fsm.sv | 48 ++++
 rtl/xdma_axil_csr_irq.sv | 207 ++++++++++++++++++++
 tb/tb_xdma_axil_csr_irq.sv | 365 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xdma_axil_csr_irq_pkg.sv
// Shared definitions for the XDMA AXI4-Lite CSR block: register offsets,
// response codes, interrupt FSM states and a strobe helper.
package xdma_csr_pkg;

    localparam logic [31:0] REG_ID        = 32'h0000_0000;
    localparam logic [31:0] REG_SCRATCH   = 32'h0000_0004;
    localparam logic [31:0] REG_CTRL      = 32'h0000_0008;
    localparam logic [31:0] REG_IRQ_PEND  = 32'h0000_000C;
    localparam logic [31:0] REG_IRQ_TRIG  = 32'h0000_0010;
    localparam logic [31:0] REG_HEARTBEAT = 32'h0000_0014;
    localparam logic [31:0] REG_STATUS    = 32'h0000_0018;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_CLR = 2'd2
    } irq_state_t;

    function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
        logic [31:0] mask;
        mask = '0;
        for (int b = 0; b < 4; b++) begin
            mask[8*b +: 8] = {8{strb[b]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/xdma_axil_csr_irq_if.sv
// AXI4-Lite bus bundle between the XDMA m_axil port (master) and the CSR block (slave).
interface xdma_axil_csr_irq_if;

    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/xdma_axil_csr_irq_fsm.sv
// Per-line usr_irq_req/usr_irq_ack handshake: request while pending and enabled,
// then hold off until software clears the pending bit.
module xdma_irq_fsm
    import xdma_csr_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic pend,
    input  logic irq_en,
    input  logic ack,
    output logic req
);

    irq_state_t state;
    irq_state_t state_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        req     = 1'b0;
        case (state)
            IDLE: begin
                if (pend && irq_en) state_n = REQ;
            end
            REQ: begin
                req = 1'b1;
                // An ack that coincides with disable still counts as delivered.
                if (ack) begin
                    state_n = WAIT_CLR;
                end else if (!irq_en) begin
                    state_n = IDLE;
                end
            end
            WAIT_CLR: begin
                if (!pend) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: rtl/xdma_axil_csr_irq.sv
// AXI4-Lite CSR slave on the XDMA BAR: ID, scratch, control, interrupt pending/trigger,
// heartbeat and link status, plus the user interrupt request lines toward xdma_0.
module xdma_axil_csr_irq
    import xdma_csr_pkg::*;
#(
    parameter int          C_NUM_USR_IRQ = 1,
    parameter int          C_DECODE_BITS = 12,
    parameter logic [31:0] C_BLOCK_ID    = 32'h5844_4D41
) (
    input  logic                     user_clk,
    input  logic                     user_reset,
    xdma_axil_csr_irq_if.slave       s_axil,
    input  logic [C_NUM_USR_IRQ-1:0] user_irq_in,
    output logic [C_NUM_USR_IRQ-1:0] usr_irq_req,
    input  logic [C_NUM_USR_IRQ-1:0] usr_irq_ack,
    input  logic                     msi_enable,
    input  logic                     user_lnk_up,
    output logic [3:0]               leds
);

    localparam logic [31:0] ADDR_MASK  = ((32'h1 << C_DECODE_BITS) - 32'h1) & 32'hFFFF_FFFC;
    localparam logic [31:0] CTRL_WMASK = 32'h0000_00F0 | ((32'h1 << C_NUM_USR_IRQ) - 32'h1);

    // Write channel state
    logic        aw_held, aw_held_n;
    logic        w_held, w_held_n;
    logic        bvalid_q, bvalid_n;
    logic        awready_q, wready_q;
    logic [1:0]  bresp_q;
    logic [31:0] aw_addr_q;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;

    // Read channel state
    logic        arready_q, rvalid_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;

    // Register file
    logic [31:0]              scratch;
    logic [31:0]              ctrl;
    logic [31:0]              heartbeat;
    logic [C_NUM_USR_IRQ-1:0] pend;
    logic [C_NUM_USR_IRQ-1:0] user_irq_in_p1;

    logic aw_hs, w_hs, b_hs, wr_fire, ar_hs, r_hs;

    logic [31:0] wr_off, wr_bmask, wr_bits;
    logic [1:0]  wr_resp;
    logic        wr_scratch, wr_ctrl, wr_trig, wr_w1c;

    logic [31:0] rd_off, rd_data;
    logic [1:0]  rd_resp;

    logic [C_NUM_USR_IRQ-1:0] irq_rise, pend_set, pend_clr;

    assign aw_hs   = s_axil.awvalid && awready_q;
    assign w_hs    = s_axil.wvalid && wready_q;
    assign b_hs    = bvalid_q && s_axil.bready;
    assign wr_fire = aw_held && w_held && !bvalid_q;
    assign ar_hs   = s_axil.arvalid && arready_q;
    assign r_hs    = rvalid_q && s_axil.rready;

    assign s_axil.awready = awready_q;
    assign s_axil.wready  = wready_q;
    assign s_axil.bvalid  = bvalid_q;
    assign s_axil.bresp   = bresp_q;
    assign s_axil.arready = arready_q;
    assign s_axil.rvalid  = rvalid_q;
    assign s_axil.rdata   = rdata_q;
    assign s_axil.rresp   = rresp_q;

    assign leds = ctrl[7:4];

    always_comb begin
        aw_held_n = aw_held;
        w_held_n  = w_held;
        bvalid_n  = bvalid_q;
        if (aw_hs)   aw_held_n = 1'b1;
        if (w_hs)    w_held_n  = 1'b1;
        if (wr_fire) bvalid_n  = 1'b1;
        if (b_hs) begin
            aw_held_n = 1'b0;
            w_held_n  = 1'b0;
            bvalid_n  = 1'b0;
        end
    end

    // Ready flags are registered from next-state so they always equal !held && !bvalid.
    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            bvalid_q  <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            aw_held   <= aw_held_n;
            w_held    <= w_held_n;
            bvalid_q  <= bvalid_n;
            awready_q <= !aw_held_n && !bvalid_n;
            wready_q  <= !w_held_n && !bvalid_n;
            if (aw_hs) aw_addr_q <= s_axil.awaddr;
            if (w_hs) begin
                w_data_q <= s_axil.wdata;
                w_strb_q <= s_axil.wstrb;
            end
            if (wr_fire) bresp_q <= wr_resp;
        end
    end

    always_comb begin
        wr_off     = aw_addr_q & ADDR_MASK;
        wr_bmask   = strb_to_mask(w_strb_q);
        wr_bits    = w_data_q & wr_bmask;
        wr_resp    = RESP_OKAY;
        wr_scratch = 1'b0;
        wr_ctrl    = 1'b0;
        wr_trig    = 1'b0;
        wr_w1c     = 1'b0;
        case (wr_off)
            REG_ID, REG_HEARTBEAT, REG_STATUS: ;
            REG_SCRATCH:  wr_scratch = wr_fire;
            REG_CTRL:     wr_ctrl    = wr_fire;
            REG_IRQ_PEND: wr_w1c     = wr_fire;
            REG_IRQ_TRIG: wr_trig    = wr_fire;
            default:      wr_resp    = RESP_SLVERR;
        endcase
    end

    // Set has priority over W1C on the same bit.
    always_comb begin
        irq_rise = user_irq_in & ~user_irq_in_p1;
        pend_set = irq_rise | (wr_trig ? wr_bits[C_NUM_USR_IRQ-1:0] : '0);
        pend_clr = wr_w1c ? wr_bits[C_NUM_USR_IRQ-1:0] : '0;
    end

    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            scratch        <= '0;
            ctrl           <= '0;
            heartbeat      <= '0;
            pend           <= '0;
            user_irq_in_p1 <= '0;
        end else begin
            heartbeat      <= heartbeat + 32'd1;
            user_irq_in_p1 <= user_irq_in;
            pend           <= (pend & ~pend_clr) | pend_set;
            if (wr_scratch) scratch <= (scratch & ~wr_bmask) | wr_bits;
            if (wr_ctrl)    ctrl    <= (ctrl & ~(wr_bmask & CTRL_WMASK)) | (wr_bits & CTRL_WMASK);
        end
    end

    always_comb begin
        rd_off  = s_axil.araddr & ADDR_MASK;
        rd_data = '0;
        rd_resp = RESP_OKAY;
        case (rd_off)
            REG_ID:        rd_data = C_BLOCK_ID;
            REG_SCRATCH:   rd_data = scratch;
            REG_CTRL:      rd_data = ctrl;
            REG_IRQ_PEND:  rd_data = 32'(pend);
            REG_IRQ_TRIG:  rd_data = '0;
            REG_HEARTBEAT: rd_data = heartbeat;
            REG_STATUS:    rd_data = {30'd0, msi_enable, user_lnk_up};
            default:       rd_resp = RESP_SLVERR;
        endcase
    end

    // Read data is captured at the AR handshake and held until the R handshake.
    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            if (ar_hs) begin
                rvalid_q  <= 1'b1;
                arready_q <= 1'b0;
                rdata_q   <= rd_data;
                rresp_q   <= rd_resp;
            end else if (r_hs) begin
                rvalid_q  <= 1'b0;
                arready_q <= 1'b1;
            end else begin
                arready_q <= !rvalid_q;
            end
        end
    end

    for (genvar i = 0; i < C_NUM_USR_IRQ; i++) begin : g_irq
        xdma_irq_fsm u_fsm (
            .clk    (user_clk),
            .rst    (user_reset),
            .pend   (pend[i]),
            .irq_en (ctrl[i]),
            .ack    (usr_irq_ack[i]),
            .req    (usr_irq_req[i])
        );
    end

endmodule

// File: tb/tb_xdma_axil_csr_irq.sv
// Directed plus randomized bench for xdma_axil_csr_irq with a behavioural register model.
module tb_xdma_axil_csr_irq;

    localparam int N = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] user_irq_in = '0;
    logic [N-1:0] usr_irq_req;
    logic [N-1:0] usr_irq_ack = '0;
    logic         msi_enable = 1'b0;
    logic         user_lnk_up = 1'b0;
    logic [3:0]   leds;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [31:0] m_scratch = '0;
    logic [31:0] m_ctrl    = '0;

    xdma_axil_csr_irq_if bus ();

    xdma_axil_csr_irq #(
        .C_NUM_USR_IRQ (N),
        .C_DECODE_BITS (12),
        .C_BLOCK_ID    (32'h5844_4D41)
    ) dut (
        .user_clk    (clk),
        .user_reset  (rst),
        .s_axil      (bus),
        .user_irq_in (user_irq_in),
        .usr_irq_req (usr_irq_req),
        .usr_irq_ack (usr_irq_ack),
        .msi_enable  (msi_enable),
        .user_lnk_up (user_lnk_up),
        .leds        (leds)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_start(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bus.awaddr  = a;
        bus.awvalid = 1'b1;
        bus.wdata   = d;
        bus.wstrb   = s;
        bus.wvalid  = 1'b1;
    endtask

    task automatic wr_finish(output logic [1:0] resp, output int hs_cyc, output int b_cyc);
        int   n;
        logic aw_go, w_go;
        n = 0; hs_cyc = -1; b_cyc = -1; resp = 2'bxx;
        while ((bus.awvalid || bus.wvalid) && n < 40) begin
            aw_go = bus.awvalid && bus.awready;
            w_go  = bus.wvalid && bus.wready;
            if (aw_go || w_go) hs_cyc = cyc;
            tick(); n++;
            if (aw_go) bus.awvalid = 1'b0;
            if (w_go)  bus.wvalid  = 1'b0;
        end
        bus.bready = 1'b1;
        while (!bus.bvalid && n < 40) begin tick(); n++; end
        if (bus.bvalid) begin
            b_cyc = cyc;
            resp  = bus.bresp;
            tick();
        end
        bus.bready  = 1'b0;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        check("wr_done_in_budget", 32'(n < 40), 32'd1);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [1:0] resp);
        int h, b;
        wr_start(a, d, s);
        wr_finish(resp, h, b);
    endtask

    task automatic rd_t(input logic [31:0] a, output logic [31:0] data, output logic [1:0] resp,
                        output int hs_cyc, output int r_cyc);
        int n;
        n = 0; hs_cyc = -1; r_cyc = -1; data = 'x; resp = 'x;
        bus.araddr  = a;
        bus.arvalid = 1'b1;
        bus.rready  = 1'b1;
        while (!bus.arready && n < 40) begin tick(); n++; end
        hs_cyc = cyc;
        tick();
        bus.arvalid = 1'b0;
        while (!bus.rvalid && n < 40) begin tick(); n++; end
        if (bus.rvalid) begin
            r_cyc = cyc;
            data  = bus.rdata;
            resp  = bus.rresp;
            tick();
        end
        bus.rready = 1'b0;
        check("rd_done_in_budget", 32'(n < 40), 32'd1);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] data, output logic [1:0] resp);
        int h, r;
        rd_t(a, data, resp, h, r);
    endtask

    task automatic wait_req(input string tag, input logic [N-1:0] exp);
        int n;
        n = 0;
        while (usr_irq_req !== exp && n < 20) begin tick(); n++; end
        check(tag, 32'(usr_irq_req), 32'(exp));
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

    // Reference: SCRATCH/CTRL storage plus the fixed-value and unmapped registers.
    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                               output logic [1:0] resp);
        logic [31:0] off;
        off  = a % 32'h1000 / 4 * 4;
        resp = 2'b00;
        if (off == 32'h4) m_scratch = merge(m_scratch, d, s);
        else if (off == 32'h8) m_ctrl = merge(m_ctrl, d, s) & 32'h0000_00F3;
        else if (off > 32'h18) resp = 2'b10;
    endtask

    task automatic model_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        logic [31:0] off;
        off  = a % 32'h1000 / 4 * 4;
        d    = 32'h0;
        resp = 2'b00;
        if (off == 32'h0) d = 32'h5844_4D41;
        else if (off == 32'h4) d = m_scratch;
        else if (off == 32'h8) d = m_ctrl;
        else if (off == 32'h18) d = 32'(msi_enable) * 2 + 32'(user_lnk_up);
        else if (off > 32'h18) resp = 2'b10;
    endtask

    initial begin
        logic [31:0] d, ed, a;
        logic [1:0]  r, er;
        int          h1, r1, h2, r2, n;
        logic        ok;
        logic [31:0] offs [6];

        offs[0] = 32'h004; offs[1] = 32'h008; offs[2] = 32'h040;
        offs[3] = 32'h000; offs[4] = 32'h018; offs[5] = 32'h7FC;

        bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
        bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

        // Reset values
        repeat (3) tick();
        check("rst_handshake_flags",
              32'({bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid}), 32'd0);
        check("rst_resps", 32'({bus.bresp, bus.rresp}), 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        check("rst_req_leds", 32'({usr_irq_req, leds}), 32'd0);
        rst = 1'b0;
        tick();

        // ID, latency and decode aliasing
        rd_t(32'h0000_0000, d, r, h1, r1);
        check("id_rdata", d, 32'h5844_4D41);
        check("id_rresp", 32'(r), 32'd0);
        check("rd_latency", 32'(r1 - h1), 32'd1);
        rd(32'hABCD_E000, d, r);
        check("id_alias_upper_bits", d, 32'h5844_4D41);

        user_lnk_up = 1'b1; msi_enable = 1'b1;
        rd(32'h18, d, r);
        check("status_both", d, 32'h3);
        user_lnk_up = 1'b0;
        rd(32'h18, d, r);
        check("status_msi_only", d, 32'h2);

        // Scratch byte-strobe write with minimum latency
        wr_start(32'h4, 32'hA5A5_1234, 4'b0011);
        wr_finish(r, h1, r1);
        check("wr_bresp", 32'(r), 32'd0);
        check("wr_latency", 32'(r1 - h1), 32'd2);
        m_scratch = merge(m_scratch, 32'hA5A5_1234, 4'b0011);
        rd(32'h4, d, r);
        check("scratch_strobe_readback", d, 32'h0000_1234);

        // W ahead of AW, then B held off with a second write waiting
        bus.bready = 1'b0;
        bus.wdata = 32'h1111_2222; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        ok = bus.wready;
        tick();
        bus.wvalid = 1'b0;
        check("w_early_accepted", 32'(ok), 32'd1);
        check("wready_low_while_held", 32'(bus.wready), 32'd0);
        tick(); tick();
        bus.awaddr = 32'h4; bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        n = 0;
        while (!bus.bvalid && n < 10) begin tick(); n++; end
        check("late_aw_bvalid", 32'(bus.bvalid), 32'd1);
        wr_start(32'h4, 32'h3333_4444, 4'hF);
        ok = 1'b1;
        repeat (5) begin
            if (bus.awready || bus.wready || !bus.bvalid) ok = 1'b0;
            tick();
        end
        check("no_accept_while_bvalid", 32'(ok), 32'd1);
        check("held_bresp", 32'(bus.bresp), 32'd0);
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        wr_finish(r, h1, r1);
        check("second_wr_bresp", 32'(r), 32'd0);
        m_scratch = 32'h3333_4444;
        rd(32'h4, d, r);
        check("second_wr_readback", d, m_scratch);

        // Unmapped offset
        rd(32'h40, d, r);
        check("unmapped_rresp", 32'(r), 32'd2);
        check("unmapped_rdata", d, 32'd0);
        wr(32'h40, 32'hFFFF_FFFF, 4'hF, r);
        check("unmapped_bresp", 32'(r), 32'd2);
        wr(32'h0, 32'h1234_5678, 4'hF, r);
        check("ro_write_okay", 32'(r), 32'd0);
        rd(32'h0, d, r);
        check("ro_write_ignored", d, 32'h5844_4D41);

        // Heartbeat advances once per clock
        rd_t(32'h14, ed, r, h1, r1);
        repeat ($urandom_range(3, 17)) tick();
        rd_t(32'h14, d, r, h2, r2);
        check("heartbeat_rate", d - ed, 32'(h2 - h1));

        // Host-triggered interrupt on line 0
        wr(32'h8, 32'h1, 4'hF, r); m_ctrl = 32'h1;
        wr(32'h10, 32'h1, 4'hF, r);
        wait_req("trig_req", 2'b01);
        usr_irq_ack = 2'b01;
        tick();
        usr_irq_ack = 2'b00;
        check("req_drop_after_ack", 32'(usr_irq_req), 32'd0);
        ok = 1'b1;
        repeat (5) begin
            if (usr_irq_req !== 2'b00) ok = 1'b0;
            tick();
        end
        check("req_stays_low_wait_clr", 32'(ok), 32'd1);
        rd(32'hC, d, r);
        check("pend_after_ack", d, 32'h1);
        wr(32'hC, 32'h1, 4'hF, r);
        rd(32'hC, d, r);
        check("pend_after_w1c", d, 32'h0);
        wr(32'h10, 32'h1, 4'hF, r);
        wait_req("retrigger_req", 2'b01);
        wr(32'h8, 32'h0, 4'hF, r); m_ctrl = 32'h0;
        check("disable_drops_req", 32'(usr_irq_req), 32'd0);
        rd(32'hC, d, r);
        check("pend_kept_after_disable", d, 32'h1);
        wr(32'hC, 32'h1, 4'hF, r);

        // Logic-triggered interrupt on line 1 while disabled
        user_irq_in = 2'b10;
        tick();
        user_irq_in = 2'b00;
        rd(32'hC, d, r);
        check("user_irq_pend", d, 32'h2);
        check("user_irq_no_req_disabled", 32'(usr_irq_req), 32'd0);
        wr(32'h8, 32'h2, 4'hF, r); m_ctrl = 32'h2;
        wait_req("enable_raises_req", 2'b10);
        usr_irq_ack = 2'b10;
        tick();
        usr_irq_ack = 2'b00;
        check("line1_drop_after_ack", 32'(usr_irq_req), 32'd0);
        wr(32'hC, 32'h2, 4'hF, r);
        wr(32'h8, 32'h0, 4'hF, r); m_ctrl = 32'h0;

        // Randomized SCRATCH/CTRL/RO/unmapped traffic against the model
        for (int i = 0; i < 40; i++) begin
            a = ($urandom() & 32'hFFFF_F000) | offs[$urandom_range(0, 5)];
            user_lnk_up = 1'($urandom_range(0, 1));
            msi_enable  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom();
                n = $urandom_range(0, 15);
                wr(a, d, 4'(n), r);
                model_write(a, d, 4'(n), er);
                check("rand_bresp", 32'(r), 32'(er));
                check("rand_leds", 32'(leds), m_ctrl / 16 % 16);
            end else begin
                rd(a, d, r);
                model_read(a, ed, er);
                check("rand_rdata", d, ed);
                check("rand_rresp", 32'(r), 32'(er));
            end
        end

        // Reset while a write response is outstanding
        wr(32'h4, 32'hCAFE_0001, 4'hF, r);
        wr(32'h8, 32'hF1, 4'hF, r);
        check("leds_before_reset", 32'(leds), 32'hF);
        wr(32'h10, 32'h1, 4'hF, r);
        wait_req("req_before_reset", 2'b01);
        bus.bready = 1'b0;
        wr_start(32'h4, 32'hDEAD_BEEF, 4'hF);
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        n = 0;
        while (!bus.bvalid && n < 10) begin tick(); n++; end
        check("bvalid_before_reset", 32'(bus.bvalid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_flags",
              32'({bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid}), 32'd0);
        check("mid_rst_resp_data", bus.rdata | 32'({bus.bresp, bus.rresp}), 32'd0);
        check("mid_rst_req_leds", 32'({usr_irq_req, leds}), 32'd0);
        tick(); tick();
        rst = 1'b0;
        ok = 1'b1;
        repeat (5) begin
            if (bus.bvalid || bus.rvalid || usr_irq_req != 2'b00) ok = 1'b0;
            tick();
        end
        check("no_spurious_after_reset", 32'(ok), 32'd1);
        m_scratch = '0; m_ctrl = '0;
        rd(32'h4, d, r);
        check("scratch_cleared_by_reset", d, m_scratch);
        rd(32'hC, d, r);
        check("pend_cleared_by_reset", d, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
